// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared bus map, register bit indices and status packing for the spike FIFO
package snn_pkg;

  localparam int WORD_W = 32;

  // Word addresses on the register bus
  localparam int ADDR_STATUS    = 0;
  localparam int ADDR_CTRL      = 1;
  localparam int ADDR_DATA_BASE = 2;

  // CTRL write bits
  localparam int CTRL_POP_BIT     = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_FLUSH_BIT   = 2;

  // STATUS read bits
  localparam int STAT_OVF_BIT   = 31;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_COUNT_W   = 16;

  // Decoded CTRL write actions for one bus cycle
  typedef struct packed {
    logic pop;
    logic clr_ovf;
    logic flush;
  } ctrl_cmd_t;

  // Assemble the STATUS word from flags and a zero-extended count
  function automatic logic [WORD_W-1:0] build_status(
    input logic                    ovf,
    input logic                    full,
    input logic                    empty,
    input logic [STAT_COUNT_W-1:0] count
  );
    logic [WORD_W-1:0] w;
    w                 = '0;
    w[STAT_OVF_BIT]   = ovf;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_COUNT_W-1:0] = count;
    return w;
  endfunction

endpackage

// File: rtl/spike_frame_fifo.sv
// rtl/spike_frame_fifo.sv - circular frame FIFO with push/pop/flush and head output
module spike_frame_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic pop_ok;
  logic push_ok;
  logic mem_we;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok & ~flush_i;
  assign mem_we  = push_ok & ~flush_i & ~rst_i;

  // Next pointers and occupancy; flush overrides any push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Frame storage, deliberately without reset so it maps to plain registers or LUT RAM
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/neuron_spike_fifo.sv
// rtl/neuron_spike_fifo.sv - spike frame buffer with register bus, overflow flag and interrupt
module neuron_spike_fifo
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 64,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [WORD_W-1:0]      d_i,
  output logic [WORD_W-1:0]      d_o,
  output logic                   ack_o,
  input  logic [NUM_NEURONS-1:0] external_spike_data_i,
  input  logic                   external_write_en_i,
  output logic                   full_o,
  output logic                   irq_o
);

  localparam int NUM_WORDS = NUM_NEURONS / WORD_W;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic                   ack_q, ack_d;
  logic [WORD_W-1:0]      d_q, d_d;
  logic                   ovf_q, ovf_d;

  logic                   bus_rd;
  logic                   bus_wr;
  ctrl_cmd_t              cmd;
  logic [WORD_W-1:0]      rdata;

  logic [NUM_NEURONS-1:0] head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_drop;
  logic [CNT_W-1:0]       fifo_count;

  // Only the low CTRL bits carry meaning; the rest of the write word is ignored
  logic                   unused_ctrl_bits;
  assign unused_ctrl_bits = ^d_i[WORD_W-1:CTRL_FLUSH_BIT+1];

  assign bus_rd = en_i & ~we_i;
  assign bus_wr = en_i & we_i;

  // CTRL write decode; every other write address is a no-op
  always_comb begin
    cmd = '0;
    if (bus_wr && addr_i == ADDR_W'(ADDR_CTRL)) begin
      cmd.pop     = d_i[CTRL_POP_BIT];
      cmd.clr_ovf = d_i[CTRL_CLR_OVF_BIT];
      cmd.flush   = d_i[CTRL_FLUSH_BIT];
    end
  end

  spike_frame_fifo #(
    .WIDTH (NUM_NEURONS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (external_write_en_i),
    .pop_i   (cmd.pop),
    .flush_i (cmd.flush),
    .din_i   (external_spike_data_i),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_count)
  );

  // Read mux; data words show the pre-pop head and read as zero when empty
  always_comb begin
    rdata = '0;
    if (addr_i == ADDR_W'(ADDR_STATUS)) begin
      rdata = build_status(ovf_q, fifo_full, fifo_empty, STAT_COUNT_W'(fifo_count));
    end else if (!fifo_empty) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (addr_i == ADDR_W'(ADDR_DATA_BASE + k)) rdata = head[WORD_W*k +: WORD_W];
      end
    end
  end

  // Next bus response and overflow flag; a drop in the same cycle beats a clear
  always_comb begin
    ack_d = en_i;
    d_d   = bus_rd ? rdata : d_q;
    ovf_d = ovf_q;
    if (fifo_drop)        ovf_d = 1'b1;
    else if (cmd.clr_ovf) ovf_d = 1'b0;
  end

  // Bus response and flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      d_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      d_q   <= d_d;
      ovf_q <= ovf_d;
    end
  end

  assign ack_o  = ack_q;
  assign d_o    = d_q;
  assign full_o = fifo_full;
  assign irq_o  = ~fifo_empty;

endmodule
